// File: rtl/vend_pkg.sv
// vend_pkg: state encoding and default sizing shared by the vending machine files.
package vend_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;
    localparam int DEF_N_ITEMS = 8;
    localparam int DEF_COIN_W = 5;
    localparam int DEF_CREDIT_W = 8;
    localparam int DEF_STOCK_W = 4;
    localparam int DEF_MAX_CREDIT = 200;
endpackage

// File: rtl/vend_table.sv
// vend_table: per-item price and stock registers with one write port, a stock decrement port
// and a combinational read by item.
module vend_table #(
    parameter int N_ITEMS = 8,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W = 4,
    parameter int IW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IW-1:0]       wr_item,
    input  logic [CREDIT_W-1:0] wr_price,
    input  logic [STOCK_W-1:0]  wr_stock,
    input  logic                dec,
    input  logic [IW-1:0]       dec_item,
    input  logic [IW-1:0]       rd_item,
    output logic [CREDIT_W-1:0] rd_price,
    output logic [STOCK_W-1:0]  rd_stock
);
    logic [CREDIT_W-1:0] price [N_ITEMS];
    logic [STOCK_W-1:0]  stock [N_ITEMS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                price[i] <= '0;
                stock[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (we && wr_item == IW'(i)) begin
                    price[i] <= wr_price;
                    stock[i] <= wr_stock;
                end else if (dec && dec_item == IW'(i) && stock[i] != '0)
                    stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    assign rd_price = price[rd_item];
    assign rd_stock = stock[rd_item];
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending FSM with credit accumulation, sold-out/need-more
// checks, a single vend pulse per purchase and a one-cycle change payout.
module vending_machine_multi import vend_pkg::*; #(
    parameter int N_ITEMS = DEF_N_ITEMS,
    parameter int COIN_W = DEF_COIN_W,
    parameter int CREDIT_W = DEF_CREDIT_W,
    parameter int STOCK_W = DEF_STOCK_W,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         coin_valid,
    input  logic [COIN_W-1:0]            coin_val,
    input  logic                         sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0]   sel_item,
    input  logic                         cancel,
    input  logic                         cfg_we,
    input  logic [$clog2(N_ITEMS)-1:0]   cfg_item,
    input  logic [CREDIT_W-1:0]          cfg_price,
    input  logic [STOCK_W-1:0]           cfg_stock,
    output logic                         vend,
    output logic [$clog2(N_ITEMS)-1:0]   vend_item,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change,
    output logic                         coin_reject,
    output logic                         sold_out,
    output logic                         need_more,
    output logic [CREDIT_W-1:0]          credit,
    output logic [1:0]                   state
);
    localparam int IW = $clog2(N_ITEMS);
    localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              st;
    logic                sel_ok, cfg_ok, do_cancel, do_sel;
    logic [CREDIT_W-1:0] rd_price;
    logic [STOCK_W-1:0]  rd_stock;
    logic [CREDIT_W:0]   sum, diff;

    if (N_ITEMS == (1 << IW)) begin : g_full
        assign sel_ok = 1'b1;
        assign cfg_ok = 1'b1;
    end else begin : g_part
        assign sel_ok = 32'(sel_item) < N_ITEMS;
        assign cfg_ok = 32'(cfg_item) < N_ITEMS;
    end

    // In VEND the table is addressed by the latched item so the price can be deducted.
    vend_table #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W), .IW(IW)) u_tab (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cfg_we && cfg_ok && st == IDLE),
        .wr_item  (cfg_item),
        .wr_price (cfg_price),
        .wr_stock (cfg_stock),
        .dec      (st == VEND),
        .dec_item (vend_item),
        .rd_item  (st == VEND ? vend_item : sel_item),
        .rd_price (rd_price),
        .rd_stock (rd_stock)
    );

    assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
    assign diff = {1'b0, credit} - {1'b0, rd_price};
    assign do_cancel = cancel && st == COLLECT;
    assign do_sel = sel_valid && sel_ok;
    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            credit <= '0;
            vend <= 1'b0;
            vend_item <= '0;
            change_valid <= 1'b0;
            change <= '0;
            coin_reject <= 1'b0;
            sold_out <= 1'b0;
            need_more <= 1'b0;
        end else begin
            vend <= 1'b0;
            change_valid <= 1'b0;
            change <= '0;
            coin_reject <= 1'b0;
            sold_out <= 1'b0;
            need_more <= 1'b0;
            case (st)
                IDLE, COLLECT: begin
                    if (do_cancel) begin
                        st <= CHANGE;
                        change_valid <= 1'b1;
                        change <= credit;
                        coin_reject <= coin_valid;
                    end else if (do_sel) begin
                        coin_reject <= coin_valid;
                        if (rd_stock == '0)
                            sold_out <= 1'b1;
                        else if (diff[CREDIT_W])
                            need_more <= 1'b1;
                        else begin
                            st <= VEND;
                            vend <= 1'b1;
                            vend_item <= sel_item;
                        end
                    end else if (coin_valid) begin
                        if (sum > MAXC)
                            coin_reject <= 1'b1;
                        else begin
                            credit <= sum[CREDIT_W-1:0];
                            st <= COLLECT;
                        end
                    end
                end
                VEND: begin
                    credit <= diff[CREDIT_W-1:0];
                    st <= diff != '0 ? CHANGE : IDLE;
                    change_valid <= diff != '0;
                    change <= diff[CREDIT_W-1:0];
                    coin_reject <= coin_valid;
                end
                CHANGE: begin
                    credit <= '0;
                    st <= IDLE;
                    coin_reject <= coin_valid;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed purchase, refund, sold-out, overflow and reset scenarios
// with hand-computed expectations.
module tb_vending_machine_multi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [4:0] coin_val = '0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_item = '0;
    logic       cancel = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_item = '0;
    logic [7:0] cfg_price = '0;
    logic [3:0] cfg_stock = '0;
    logic       vend, change_valid, coin_reject, sold_out, need_more;
    logic [2:0] vend_item;
    logic [7:0] change, credit;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;

    vending_machine_multi dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .cfg_we(cfg_we),
        .cfg_item(cfg_item), .cfg_price(cfg_price), .cfg_stock(cfg_stock), .vend(vend),
        .vend_item(vend_item), .change_valid(change_valid), .change(change),
        .coin_reject(coin_reject), .sold_out(sold_out), .need_more(need_more),
        .credit(credit), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic cv, input logic [4:0] cval, input logic sv, input logic [2:0] si,
                       input logic cn);
        coin_valid = cv; coin_val = cval; sel_valid = sv; sel_item = si; cancel = cn;
        @(posedge clk); #1;
        coin_valid = 1'b0; coin_val = '0; sel_valid = 1'b0; sel_item = '0; cancel = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] it, input logic [7:0] pr, input logic [3:0] sk);
        cfg_we = 1'b1; cfg_item = it; cfg_price = pr; cfg_stock = sk;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_item = '0; cfg_price = '0; cfg_stock = '0;
    endtask

    initial begin
        #2;
        chk("rst_state", state, 0);
        chk("rst_credit", credit, 0);
        chk("rst_pulses", {vend, change_valid, coin_reject, sold_out, need_more}, 0);
        chk("rst_change", change, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Scenario 1: buy item 4 (35) with 40, expect change 5
        cfg(3'd4, 8'd35, 4'd2);
        chk("s1_cfg_stock", dut.u_tab.stock[4], 2);
        cyc(1, 5'd10, 0, 0, 0);
        chk("s1_credit10", credit, 10);
        chk("s1_collect", state, 1);
        cyc(1, 5'd20, 0, 0, 0);
        cyc(1, 5'd10, 0, 0, 0);
        chk("s1_credit40", credit, 40);
        cyc(0, 0, 1, 3'd4, 0);
        chk("s1_vend", vend, 1);
        chk("s1_vend_item", vend_item, 4);
        chk("s1_vend_state", state, 2);
        cyc(0, 0, 0, 0, 0);
        chk("s1_vend_off", vend, 0);
        chk("s1_vend_item_hold", vend_item, 4);
        chk("s1_change_valid", change_valid, 1);
        chk("s1_change", change, 5);
        chk("s1_change_state", state, 3);
        chk("s1_stock", dut.u_tab.stock[4], 1);
        cyc(0, 0, 0, 0, 0);
        chk("s1_idle", state, 0);
        chk("s1_credit0", credit, 0);
        chk("s1_change_zero", {change_valid, change}, 0);

        // Scenario 2: exact payment, no change
        cyc(1, 5'd20, 0, 0, 0);
        cyc(1, 5'd15, 0, 0, 0);
        cyc(0, 0, 1, 3'd4, 0);
        chk("s2_vend", vend, 1);
        cyc(0, 0, 0, 0, 0);
        chk("s2_no_change", change_valid, 0);
        chk("s2_idle", state, 0);
        chk("s2_credit", credit, 0);
        chk("s2_stock", dut.u_tab.stock[4], 0);

        // Scenario 3: need_more then cancel refund
        cfg(3'd4, 8'd35, 4'd2);
        cyc(1, 5'd10, 0, 0, 0);
        cyc(0, 0, 1, 3'd4, 0);
        chk("s3_need_more", need_more, 1);
        chk("s3_credit", credit, 10);
        chk("s3_state", state, 1);
        cyc(0, 0, 0, 0, 1);
        chk("s3_refund_valid", change_valid, 1);
        chk("s3_refund", change, 10);
        cyc(0, 0, 0, 0, 0);
        chk("s3_credit0", credit, 0);
        chk("s3_idle", state, 0);

        // Scenario 4: sold out
        cfg(3'd4, 8'd35, 4'd0);
        cyc(1, 5'd31, 0, 0, 0);
        cyc(0, 0, 1, 3'd4, 0);
        chk("s4_sold_out", sold_out, 1);
        chk("s4_no_vend", vend, 0);
        chk("s4_credit", credit, 31);
        chk("s4_state", state, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // Scenario 5: credit ceiling, coin/select collision, coin in VEND, cancel ignored
        cfg(3'd2, 8'd50, 4'd3);
        for (int i = 0; i < 6; i++) cyc(1, 5'd31, 0, 0, 0);
        cyc(1, 5'd9, 0, 0, 0);
        chk("s5_credit195", credit, 195);
        cyc(1, 5'd10, 0, 0, 0);
        chk("s5_reject", coin_reject, 1);
        chk("s5_credit_kept", credit, 195);
        cyc(1, 5'd5, 0, 0, 0);
        chk("s5_max_ok", coin_reject, 0);
        chk("s5_credit200", credit, 200);
        cyc(1, 5'd5, 1, 3'd2, 0);
        chk("s5_sel_wins", vend, 1);
        chk("s5_sel_item", vend_item, 2);
        chk("s5_coin_lost", coin_reject, 1);
        chk("s5_credit_vend", credit, 200);
        cyc(1, 5'd1, 0, 0, 0);
        chk("s5_coin_in_vend", coin_reject, 1);
        chk("s5_change", change, 150);
        chk("s5_change_state", state, 3);
        cyc(0, 0, 0, 0, 1);
        chk("s5_idle", state, 0);
        chk("s5_credit0", credit, 0);
        cyc(0, 0, 0, 0, 1);
        chk("s5_cancel_idle", {state, change_valid}, 0);

        // Scenario 6: cfg ignored in COLLECT, async reset during VEND
        cfg(3'd1, 8'd20, 4'd5);
        cyc(1, 5'd20, 0, 0, 0);
        cfg(3'd1, 8'd99, 4'd9);
        chk("s6_cfg_price_kept", dut.u_tab.price[1], 20);
        chk("s6_cfg_stock_kept", dut.u_tab.stock[1], 5);
        cyc(0, 0, 1, 3'd1, 0);
        chk("s6_in_vend", state, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_rst_state", state, 0);
        chk("s6_rst_credit", credit, 0);
        chk("s6_rst_outs", {vend, vend_item, change_valid, change, coin_reject, sold_out, need_more}, 0);
        chk("s6_rst_price", dut.u_tab.price[1], 0);
        chk("s6_rst_stock", dut.u_tab.stock[1], 0);
        #1 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("s6_no_change", {state, change_valid}, 0);
        cyc(1, 5'd10, 0, 0, 0);
        chk("s6_resume", credit, 10);
        cyc(0, 0, 1, 3'd1, 0);
        chk("s6_cleared_sold_out", sold_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 SHALL have parameter N_ITEMS, default 8, the number of selectable items (index 0..N_ITEMS-1).
REQ-002 SHALL have parameter COIN_W, default 5, the coin value width.
REQ-003 SHALL have parameter CREDIT_W, default 8, the width of credit, price and change.
REQ-004 SHALL have parameter STOCK_W, default 4, the per-item stock counter width.
REQ-005 SHALL have parameter MAX_CREDIT, default 200, the highest credit ever held (MAX_CREDIT < 2**CREDIT_W).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-008 SHALL have ports coin_valid (input, 1) and coin_val (input, COIN_W), a one-cycle coin insertion strobe and its value.
REQ-009 SHALL have ports sel_valid (input, 1) and sel_item (input, clog2(N_ITEMS)), a one-cycle item selection strobe and its item.
REQ-010 SHALL have port cancel, input, 1 bit, a one-cycle refund request.
REQ-011 SHALL have ports cfg_we (input, 1), cfg_item (input, clog2(N_ITEMS)), cfg_price (input, CREDIT_W) and cfg_stock (input, STOCK_W), a write of price and stock for one item.
REQ-012 SHALL have ports vend (output, 1) and vend_item (output, clog2(N_ITEMS)), a one-cycle dispense pulse and the item dispensed.
REQ-013 SHALL have ports change_valid (output, 1) and change (output, CREDIT_W), a one-cycle payout pulse and the amount paid out.
REQ-014 SHALL have ports coin_reject (output, 1), sold_out (output, 1) and need_more (output, 1), one-cycle status pulses.
REQ-015 SHALL have ports credit (output, CREDIT_W), the current credit, and state (output, 2), the current state encoding.

Function
REQ-016 SHALL implement states IDLE=0, COLLECT=1, VEND=2 and CHANGE=3; state equals the registered FSM state.
REQ-017 IDLE/COLLECT: accepted coin SHALL add coin_val to credit next cycle, and the FSM SHALL go to or stay in COLLECT.
REQ-018 A coin with credit+coin_val > MAX_CREDIT SHALL be rejected: coin_reject pulses next cycle and credit is unchanged.
REQ-019 A coin arriving in VEND or CHANGE SHALL be rejected with coin_reject.
REQ-020 Selection in IDLE/COLLECT with stock[sel_item]==0 SHALL pulse sold_out and leave credit and state unchanged.
REQ-021 Selection with credit < price[sel_item] SHALL pulse need_more and leave credit and state unchanged.
REQ-022 Otherwise selection SHALL go to VEND; in VEND, vend=1 and vend_item=the latched item for exactly one cycle, stock is decremented by 1, and credit is reduced by the price.
REQ-023 After VEND, the FSM SHALL go to CHANGE if the remaining credit > 0, else to IDLE.
REQ-024 In CHANGE, change_valid=1 and change=credit for one cycle; credit is cleared and the FSM goes to IDLE.
REQ-025 cancel in COLLECT SHALL go to CHANGE (full refund); cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-026 Same-cycle priority SHALL be cancel > sel_valid > coin_valid; a coin that loses arbitration SHALL be rejected.
REQ-027 cfg_we SHALL be honoured only in IDLE; it is ignored in other states, and the write takes effect the next cycle.
REQ-028 A sel_item or cfg_item >= N_ITEMS SHALL be ignored, with no pulse.
REQ-029 Stock SHALL never wrap: stock is decremented only on vend, which requires stock > 0.
REQ-030 Outputs SHALL be registered; change is 0 whenever change_valid=0; vend_item holds its value when vend=0.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, credit=0, and all pulse outputs, change and vend_item to 0.
REQ-032 rst_n low SHALL clear every price and stock entry to 0, so all items read as sold out.
REQ-033 Reset mid-transaction SHALL discard the credit with no change pulse; operation resumes on the first clk edge after rst_n deasserts.

Structure
REQ-034 Package vend_pkg SHALL hold the state enum, the state encodings and the default parameter constants.
REQ-035 Price and stock storage SHALL be a sub-module, vend_table, containing registers, the write port, the decrement port and a combinational read by item.
REQ-036 The top level SHALL contain only the FSM, the credit arithmetic and the output registers; credit arithmetic is done at CREDIT_W+1 bits for overflow detection.

Verification
REQ-037 Scenario 1: cfg item4 price=35 stock=2; coins 10, 20, 10; select 4 -> credit=40, vend with vend_item=4, then change_valid with change=5, stock[4]=1, IDLE.
REQ-038 Scenario 2: exact pay item4 with coins 20, 15 -> vend, no change_valid, IDLE next cycle.
REQ-039 Scenario 3: coin 10, select item4 (35) -> need_more pulse; then cancel -> change=10, credit=0.
REQ-040 Scenario 4: stock[4]=0, coin 31, select 4 -> sold_out pulse, credit remains 31.
REQ-041 Scenario 5: credit 195 + coin 10 -> coin_reject and credit stays 195; coin and select in the same cycle -> selection processed and coin_reject.
REQ-042 Scenario 6: rst_n low during VEND -> all outputs 0 and state=IDLE immediately, prices and stock cleared; cfg_we in COLLECT -> table unchanged.
